// File: rtl/m_clk_gate_ctrl_if.sv
// Channel bus for m_clk_gate_ctrl: config, per-channel activity/wake
// inputs and registered gate-enable / handshake outputs.
// Optional statistics signals exist only when CGC_STATS_EN is defined.
interface m_clk_gate_ctrl_if #(
  parameter int N_CH   = 4,
  parameter int IDLE_W = 8
);
  logic [IDLE_W-1:0] cfg_idle_thr;
  logic              force_on;
  logic [N_CH-1:0]   ch_busy;
  logic [N_CH-1:0]   ch_wake_req;
  logic [N_CH-1:0]   ch_wake_ack;
  logic [N_CH-1:0]   ch_clk_en;
  logic [N_CH-1:0]   ch_gated;
`ifdef CGC_STATS_EN
  logic               stats_clr;
  logic [N_CH*16-1:0] ch_gated_cnt;

  modport master (
    output cfg_idle_thr, force_on, ch_busy, ch_wake_req, stats_clr,
    input  ch_wake_ack, ch_clk_en, ch_gated, ch_gated_cnt
  );
  modport slave (
    input  cfg_idle_thr, force_on, ch_busy, ch_wake_req, stats_clr,
    output ch_wake_ack, ch_clk_en, ch_gated, ch_gated_cnt
  );
`else
  modport master (
    output cfg_idle_thr, force_on, ch_busy, ch_wake_req,
    input  ch_wake_ack, ch_clk_en, ch_gated
  );
  modport slave (
    input  cfg_idle_thr, force_on, ch_busy, ch_wake_req,
    output ch_wake_ack, ch_clk_en, ch_gated
  );
`endif
endinterface

// File: rtl/m_clk_gate_ctrl.sv
// N-channel clock-gate enable controller.
// Each channel runs RUN -> GATED after cfg_idle_thr consecutive idle
// cycles, and GATED -> WAKE -> RUN on busy/wake/force, holding the enable
// high for WAKE_LAT cycles before acknowledging a wake request.
// Optional per-channel gated-cycle counters: define CGC_STATS_EN.

// Per-channel gate FSM.
module cgc_chan #(
  parameter int IDLE_W   = 8,
  parameter int WAKE_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IDLE_W-1:0] thr,
  input  logic              force_on,
  input  logic              busy,
  input  logic              req,
`ifdef CGC_STATS_EN
  input  logic              stats_clr,
  output logic [15:0]       gated_cnt,
`endif
  output logic              ack,
  output logic              clk_en,
  output logic              gated
);
  localparam int WC_W = (WAKE_LAT > 1) ? $clog2(WAKE_LAT) : 1;
  localparam logic [WC_W-1:0] WAKE_LAST = WC_W'(WAKE_LAT - 1);

  typedef enum logic [1:0] {RUN, GATED, WAKE} st_e;

  st_e               st_q, st_d;
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic [WC_W-1:0]   wake_q, wake_d;
  logic              req_prev_q, req_prev_d;
  logic              ack_q, ack_d;
  logic              clk_en_q, clk_en_d;
  logic              gated_q, gated_d;

  logic              wake_src;
  logic              idle_now;
  logic [IDLE_W:0]   idle_inc;

  assign wake_src = busy | req | force_on;
  assign idle_now = !wake_src && (thr != '0);
  // one bit wider so the all-ones count still compares correctly
  assign idle_inc = {1'b0, idle_q} + (IDLE_W+1)'(1);

  // Next-state, counters and registered-output values.
  always_comb begin
    st_d       = st_q;
    idle_d     = idle_q;
    wake_d     = wake_q;
    ack_d      = 1'b0;
    req_prev_d = req;
    case (st_q)
      RUN: begin
        // only a fresh request is acked; a held one stays silent
        ack_d = req && !req_prev_q;
        if (!idle_now) begin
          idle_d = '0;
        end else if (idle_inc >= {1'b0, thr}) begin
          st_d   = GATED;
          idle_d = '0;
        end else if (idle_q != '1) begin
          idle_d = idle_q + 1'b1;
        end
      end
      GATED: begin
        if (wake_src) begin
          st_d   = WAKE;
          wake_d = '0;
        end
      end
      WAKE: begin
        if (wake_q == WAKE_LAST) begin
          st_d   = RUN;
          idle_d = '0;
          // req_prev_d follows req, so a held request is not re-acked in RUN
          ack_d  = req;
        end else begin
          wake_d = wake_q + 1'b1;
        end
      end
      default: st_d = RUN;
    endcase
    clk_en_d = (st_d != GATED);
    gated_d  = (st_d == GATED);
  end

  // State and output registers; reset forces the clock on.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q       <= RUN;
      idle_q     <= '0;
      wake_q     <= '0;
      ack_q      <= 1'b0;
      clk_en_q   <= 1'b1;
      gated_q    <= 1'b0;
      // track req through reset so a request held across it is not acked
      req_prev_q <= req_prev_d;
    end else begin
      st_q       <= st_d;
      idle_q     <= idle_d;
      wake_q     <= wake_d;
      ack_q      <= ack_d;
      clk_en_q   <= clk_en_d;
      gated_q    <= gated_d;
      req_prev_q <= req_prev_d;
    end
  end

  assign ack    = ack_q;
  assign clk_en = clk_en_q;
  assign gated  = gated_q;

`ifdef CGC_STATS_EN
  logic [15:0] cnt_q, cnt_d;

  // Saturating count of cycles spent in GATED; clear wins over count.
  always_comb begin
    cnt_d = cnt_q;
    if (stats_clr)                          cnt_d = '0;
    else if (st_q == GATED && cnt_q != '1)  cnt_d = cnt_q + 1'b1;
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign gated_cnt = cnt_q;
`endif
endmodule

module m_clk_gate_ctrl #(
  parameter int N_CH     = 4,
  parameter int IDLE_W   = 8,
  parameter int WAKE_LAT = 2
) (
  input  logic           clk,
  input  logic           rst,
  m_clk_gate_ctrl_if.slave bus
);
  logic [N_CH-1:0] ack_w;
  logic [N_CH-1:0] en_w;
  logic [N_CH-1:0] gated_w;
`ifdef CGC_STATS_EN
  logic [N_CH-1:0][15:0] cnt_w;
  assign bus.ch_gated_cnt = cnt_w;
`endif

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    cgc_chan #(
      .IDLE_W   (IDLE_W),
      .WAKE_LAT (WAKE_LAT)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .thr       (bus.cfg_idle_thr),
      .force_on  (bus.force_on),
      .busy      (bus.ch_busy[i]),
      .req       (bus.ch_wake_req[i]),
`ifdef CGC_STATS_EN
      .stats_clr (bus.stats_clr),
      .gated_cnt (cnt_w[i]),
`endif
      .ack       (ack_w[i]),
      .clk_en    (en_w[i]),
      .gated     (gated_w[i])
    );
  end

  assign bus.ch_wake_ack = ack_w;
  assign bus.ch_clk_en   = en_w;
  assign bus.ch_gated    = gated_w;
endmodule

// File: tb/tb_m_clk_gate_ctrl.sv
// Bench for m_clk_gate_ctrl (N_CH=4, IDLE_W=8, WAKE_LAT=2): vector table,
// directed corner sequences, then random traffic against a cycle model.
// Statistics checks compile in only with CGC_STATS_EN.
module tb_m_clk_gate_ctrl;
  localparam int N  = 4;
  localparam int WL = 2;

  logic clk;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   clr_r = 0;

  m_clk_gate_ctrl_if #(.N_CH(N), .IDLE_W(8)) bus ();

  m_clk_gate_ctrl #(.N_CH(N), .IDLE_W(8), .WAKE_LAT(WL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model (counts, not states) ----------------
  int   m_idle [N];   // consecutive idle cycles in RUN
  int   m_wake [N];   // remaining cycles of wake-up, 0 = not waking
  bit   m_gated[N];
  bit   m_prev [N];
  int   m_cnt  [N];
  logic [N-1:0] e_en, e_g, e_ack;

  function automatic void model_step(bit r, int thr, bit frc,
                                     logic [N-1:0] b, logic [N-1:0] q, bit clr);
    for (int i = 0; i < N; i++) begin
      bit act = b[i] | q[i] | frc;
      e_ack[i] = 1'b0;
      if (r || clr)                          m_cnt[i] = 0;
      else if (m_gated[i] && m_cnt[i] < 65535) m_cnt[i]++;
      if (r) begin
        m_gated[i] = 0; m_wake[i] = 0; m_idle[i] = 0;
      end else if (m_wake[i] > 0) begin
        m_wake[i]--;
        if (m_wake[i] == 0) begin
          m_idle[i] = 0;
          e_ack[i]  = q[i];
        end
      end else if (m_gated[i]) begin
        if (act) begin
          m_gated[i] = 0;
          m_wake[i]  = WL;
        end
      end else begin
        e_ack[i] = q[i] && !m_prev[i];
        if (act || thr == 0) m_idle[i] = 0;
        else begin
          m_idle[i]++;
          if (m_idle[i] >= thr) begin
            m_gated[i] = 1;
            m_idle[i]  = 0;
          end
        end
      end
      m_prev[i] = q[i];
      e_en[i]   = !m_gated[i];
      e_g[i]    = m_gated[i];
    end
  endfunction

  // Apply one cycle of inputs, then sample just after the edge.
  task automatic cyc(input bit r, input int thr, input bit frc,
                     input logic [N-1:0] b, input logic [N-1:0] q);
    rst                 = r;
    bus.cfg_idle_thr    = 8'(thr);
    bus.force_on        = frc;
    bus.ch_busy         = b;
    bus.ch_wake_req     = q;
`ifdef CGC_STATS_EN
    bus.stats_clr       = clr_r;
`endif
    @(posedge clk);
    #1;
    model_step(r, thr, frc, b, q, clr_r);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk3(input string nm, input logic [N-1:0] en,
                      input logic [N-1:0] g, input logic [N-1:0] a);
    chk({nm, ".clk_en"}, 32'(bus.ch_clk_en), 32'(en));
    chk({nm, ".gated"},  32'(bus.ch_gated),  32'(g));
    chk({nm, ".ack"},    32'(bus.ch_wake_ack), 32'(a));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit           r;
    int           thr;
    bit           frc;
    logic [N-1:0] b, q, en, g, ack;
  } vec_t;
  vec_t tv[$];

  function automatic void add(bit r, int thr, bit frc, logic [N-1:0] b, logic [N-1:0] q,
                              logic [N-1:0] en, logic [N-1:0] g, logic [N-1:0] ack);
    vec_t v;
    v.r = r; v.thr = thr; v.frc = frc; v.b = b; v.q = q;
    v.en = en; v.g = g; v.ack = ack;
    tv.push_back(v);
  endfunction

  initial begin
    logic [N-1:0] g_or, en_and, rq, bz;
    int           thr_r;

    // reset 3 cycles, then ch0/ch3 idle, ch1 busy in runs of 3, ch2 busy
    for (int k = 0; k < 3; k++) add(1, 4, 0, 4'b0000, 4'b0000, 4'hF, 4'h0, 4'h0);
    for (int k = 0; k < 3; k++) add(0, 4, 0, 4'b0110, 4'b0000, 4'hF, 4'h0, 4'h0);
    for (int k = 0; k < 3; k++) add(0, 4, 0, 4'b0100, 4'b0000, 4'b0110, 4'b1001, 4'h0);
    for (int k = 0; k < 2; k++) add(0, 4, 0, 4'b0110, 4'b0000, 4'b0110, 4'b1001, 4'h0);
    // wake ch0: enable next cycle, ack WAKE_LAT+1 after request
    add(0, 4, 0, 4'b0110, 4'b0001, 4'b0111, 4'b1000, 4'h0);
    add(0, 4, 0, 4'b0110, 4'b0001, 4'b0111, 4'b1000, 4'h0);
    add(0, 4, 0, 4'b0110, 4'b0001, 4'b0111, 4'b1000, 4'b0001);
    // request held: no second ack, no gating
    for (int k = 0; k < 10; k++) add(0, 4, 0, 4'b0110, 4'b0001, 4'b0111, 4'b1000, 4'h0);
    // request dropped: ch0 gates again after 4 idle cycles
    for (int k = 0; k < 3; k++) add(0, 4, 0, 4'b0110, 4'b0000, 4'b0111, 4'b1000, 4'h0);
    add(0, 4, 0, 4'b0110, 4'b0000, 4'b0110, 4'b1001, 4'h0);

    foreach (tv[k]) begin
      cyc(tv[k].r, tv[k].thr, tv[k].frc, tv[k].b, tv[k].q);
      chk3($sformatf("tbl%0d", k), tv[k].en, tv[k].g, tv[k].ack);
    end

    // thr=0: 300 idle cycles never gate
    cyc(1, 0, 0, 0, 0);
    g_or = '0; en_and = '1;
    for (int k = 0; k < 300; k++) begin
      cyc(0, 0, 0, 0, 0);
      g_or   |= bus.ch_gated;
      en_and &= bus.ch_clk_en;
    end
    chk("thr0_gated", 32'(g_or), 32'h0);
    chk("thr0_clk_en", 32'(en_and), 32'hF);

    // force_on from all-gated: WAKE next cycle, RUN after WAKE_LAT, no acks
    cyc(1, 2, 0, 0, 0);
    cyc(0, 2, 0, 0, 0);
    cyc(0, 2, 0, 0, 0);
    chk3("frc_pre", 4'h0, 4'hF, 4'h0);
    cyc(0, 2, 1, 0, 0);
    chk3("frc_wake0", 4'hF, 4'h0, 4'h0);
    cyc(0, 2, 1, 0, 0);
    chk3("frc_wake1", 4'hF, 4'h0, 4'h0);
    cyc(0, 2, 1, 0, 0);
    chk3("frc_run", 4'hF, 4'h0, 4'h0);
    cyc(0, 2, 1, 0, 0);
    chk3("frc_hold", 4'hF, 4'h0, 4'h0);

    // collision: busy (ch0) / fresh req (ch1) on the gating cycle
    cyc(1, 3, 0, 0, 0);
    cyc(0, 3, 0, 0, 0);
    cyc(0, 3, 0, 0, 0);
    cyc(0, 3, 0, 4'b0001, 4'b0010);
    chk3("coll_hit", 4'b0011, 4'b1100, 4'b0010);
    cyc(0, 3, 0, 0, 0);
    chk3("coll_after", 4'b0011, 4'b1100, 4'h0);

    // reset mid-WAKE with request held: RUN next cycle, never acked
    cyc(1, 2, 0, 0, 0);
    cyc(0, 2, 0, 0, 0);
    cyc(0, 2, 0, 0, 0);
    cyc(0, 2, 0, 0, 4'b0001);
    chk3("rstw_wake", 4'b0001, 4'b1110, 4'h0);
    cyc(1, 2, 0, 0, 4'b0001);
    chk3("rstw_rst", 4'hF, 4'h0, 4'h0);
    for (int k = 0; k < 3; k++) begin
      cyc(0, 2, 0, 0, 4'b0001);
      chk($sformatf("rstw_noack%0d", k), 32'(bus.ch_wake_ack), 32'h0);
      chk($sformatf("rstw_en%0d", k), 32'(bus.ch_clk_en[0]), 32'h1);
    end

    // request withdrawn during WAKE: completes to RUN, no ack
    cyc(1, 2, 0, 0, 0);
    cyc(0, 2, 0, 0, 0);
    cyc(0, 2, 0, 0, 0);
    cyc(0, 2, 0, 0, 4'b0001);
    cyc(0, 2, 0, 0, 0);
    chk3("viol_wake", 4'b0001, 4'b1110, 4'h0);
    cyc(0, 2, 0, 0, 0);
    chk3("viol_run", 4'b0001, 4'b1110, 4'h0);

    // lowering thr below the running count gates on the next idle cycle
    cyc(1, 10, 0, 0, 0);
    for (int k = 0; k < 5; k++) cyc(0, 10, 0, 0, 0);
    chk("thrlow_pre", 32'(bus.ch_gated), 32'h0);
    cyc(0, 3, 0, 0, 0);
    chk("thrlow_gate", 32'(bus.ch_gated), 32'hF);

    // random traffic against the model
    rq = '0; thr_r = 3;
    cyc(1, thr_r, 0, 0, 0);
    for (int k = 0; k < 3000; k++) begin
      bit r, f;
      if ($urandom_range(0, 49) == 0) thr_r = $urandom_range(0, 6);
      r = ($urandom_range(0, 199) == 0);
      f = ($urandom_range(0, 99) < 3);
      for (int i = 0; i < N; i++) begin
        bz[i] = ($urandom_range(0, 9) == 0);
        if (!rq[i]) rq[i] = ($urandom_range(0, 19) == 0);
        else if (bus.ch_wake_ack[i] || $urandom_range(0, 29) == 0) rq[i] = 1'b0;
      end
      cyc(r, thr_r, f, bz, rq);
      chk3($sformatf("rnd%0d", k), e_en, e_g, e_ack);
    end

`ifdef CGC_STATS_EN
    // gated-cycle counter on ch2: count, clear, saturate
    cyc(1, 1, 0, 4'b1011, 0);
    cyc(0, 1, 0, 4'b1011, 0);
    for (int k = 0; k < 100; k++) cyc(0, 1, 0, 4'b1011, 0);
    chk("stat_100", 32'(bus.ch_gated_cnt[47:32]), 32'd100);
    chk("stat_ch0", 32'(bus.ch_gated_cnt[15:0]), 32'd0);
    clr_r = 1;
    cyc(0, 1, 0, 4'b1011, 0);
    clr_r = 0;
    chk("stat_clr", 32'(bus.ch_gated_cnt[47:32]), 32'd0);
    for (int k = 0; k < 70000; k++) cyc(0, 1, 0, 4'b1011, 0);
    chk("stat_sat", 32'(bus.ch_gated_cnt[47:32]), 32'hFFFF);
    chk("stat_model", 32'(bus.ch_gated_cnt[47:32]), 32'(m_cnt[2]));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/m_clk_gate_ctrl.md
Name: m_clk_gate_ctrl

Overview:
- Parametrised N-channel clock-gate enable controller; successor to the single two-input clock-AND cell.
- Per channel, it tracks activity and drops the clock enable after a programmable run of idle cycles.
- It re-enables the clock on a busy or wake request and acknowledges once the clock is stable.
- ch_clk_en outputs drive the per-channel clock-AND cells in the clock tree; the controller itself sits on the free-running clock.

Parameters:
- N_CH, 4, number of gated channels (1..32)
- IDLE_W, 8, width of idle counter and threshold
- WAKE_LAT, 2, cycles clk_en is held high in WAKE before ack/RUN (>=1)

Ports:
- clk  in  1  free-running clock
- rst  in  1  synchronous reset, active-high
- cfg_idle_thr  in  IDLE_W  consecutive idle cycles before gating; 0 = auto-gating disabled
- force_on  in  1  global override; keeps or brings all channels to RUN
- ch_busy  in  N_CH  per-channel activity, level
- ch_wake_req  in  N_CH  per-channel wake request, level, held until ack
- ch_wake_ack  out  N_CH  one-cycle ack pulse
- ch_clk_en  out  N_CH  clock enable to gate cell (1 = clock runs)
- ch_gated  out  N_CH  1 while channel in GATED

Behaviour:
- Reset, synchronous: all channels RUN, ch_clk_en all 1 (fail-safe on), ch_wake_ack=0, ch_gated=0, idle/wake counters=0. Reset mid-WAKE or mid-GATED returns the channel to RUN the next cycle with no ack.
- All outputs are registered.
- Channels are independent; state below is per channel, with three states: RUN, GATED, WAKE.
- RUN (clk_en=1, gated=0):
  - If busy or wake_req or force_on, or thr==0: idle_cnt<=0.
  - Otherwise idle_cnt increments, saturating at all-ones.
  - Gate condition: idle_cnt+1 >= thr with the idle conditions above true. Then go to GATED; clk_en falls on the cycle after the thr-th consecutive idle cycle.
  - Comparison is >=, so lowering thr below the current count gates on the next idle cycle.
  - wake_req in RUN: ack pulses the next cycle, but only on the rising edge of wake_req (req seen low the previous cycle). No duplicate acks while req is held.
- GATED (clk_en=0, gated=1):
  - busy or wake_req or force_on -> WAKE, with wake_cnt<=0.
  - thr changes are ignored.
- WAKE (clk_en=1, gated=0):
  - wake_cnt increments each cycle.
  - When wake_cnt==WAKE_LAT-1 -> RUN, with idle_cnt<=0.
  - On that same transition, ack pulses if wake_req is high. Req edge tracking is marked consumed, so there is no second ack in RUN.
  - Exit latency from req asserted in GATED to ack: WAKE_LAT+1 cycles.
  - A busy-only wake produces no ack.
- Simultaneous events:
  - Wake/busy in the same cycle as the gate condition: wake wins, stay RUN.
  - force_on overrides everything except rst.
  - wake_req deasserted during WAKE (protocol violation): complete WAKE, go RUN, no ack.
- ch_clk_en changes only on clk rising edge. Glitch-freedom is guaranteed by the downstream latch-based gate cell, not by this block.

Optional Feature:
- Macro CGC_STATS_EN. When defined, the following are added:
  - Input stats_clr (1).
  - Output ch_gated_cnt (N_CH*16), where channel i occupies bits [16i+15:16i].
  - Each 16-bit counter increments every cycle the channel is in GATED, saturating at 16'hFFFF.
  - stats_clr (sync, priority over increment) and rst zero all counters.
- When not defined: neither port exists, no counter logic is present, and all other behaviour is identical.

Test Plan:
- Reset: assert rst 3 cycles with busy=0, thr=4 -> during and 1 cycle after rst, clk_en=4'hF, gated=0, ack=0.
- Auto-gate: thr=4, ch0 busy=0 from cycle 0 -> ch0 clk_en=0 and gated=1 at cycle 4; busy toggling every 3 cycles on ch1 keeps ch1 clk_en=1 throughout.
- Wake handshake: ch0 GATED, raise wake_req at cycle T with WAKE_LAT=2 -> clk_en=1 at T+1, single ack pulse at T+3, state RUN; hold req 10 more cycles -> no further ack, no gating.
- thr=0 / force_on:
  - thr=0 with 300 idle cycles -> never gated.
  - All channels GATED, force_on=1 -> all enter WAKE next cycle and RUN after WAKE_LAT, no acks.
- Collision / mid-op reset:
  - busy rises on the cycle the gate condition would fire -> clk_en stays 1.
  - rst during WAKE -> RUN next cycle, ack never pulses.
- CGC_STATS_EN: gate ch2 for 100 cycles -> ch_gated_cnt[47:32]=100; stats_clr pulse -> 0 next cycle; force 70000 gated cycles -> saturates at 16'hFFFF.
